// File: rtl/iscore_pkg.sv
// Shared score-display definitions: note-entry layout, array sizing, window
// geometry and the note_window scan FSM states.
package iscore_pkg;

   localparam int unsigned DISPLAYED_BEATS    = 4;
   localparam int unsigned SIMULTANEOUS_NOTES = 4;
   localparam int unsigned BEAT_DURATION      = 48;
   localparam int unsigned BEAT_BITS          = 16;
   localparam int unsigned NOTE_BITS          = 7;
   localparam int unsigned ADDR_BITS          = 12;

   localparam int unsigned NOTE_STATE_BITS  = NOTE_BITS + 2 * BEAT_BITS;
   localparam int unsigned NOTES_STATE_SIZE = 2 * DISPLAYED_BEATS * SIMULTANEOUS_NOTES;

   // Entry layout, MSB to LSB: {note, start, duration}
   localparam int unsigned DUR_LSB   = 0;
   localparam int unsigned START_LSB = BEAT_BITS;
   localparam int unsigned NOTE_LSB  = 2 * BEAT_BITS;

   localparam int unsigned WINDOW_SPAN = DISPLAYED_BEATS * BEAT_DURATION;
   localparam int unsigned SLOT_BITS   = $clog2(NOTES_STATE_SIZE + 1);
   localparam int unsigned IDX_BITS    = $clog2(NOTES_STATE_SIZE);

   typedef logic [NOTE_STATE_BITS-1:0] note_entry_t;

   localparam note_entry_t EMPTY_ENTRY = '0;

   typedef enum logic [1:0] {
      NW_IDLE,
      NW_ISSUE,
      NW_EVAL,
      NW_DONE
   } nw_state_t;

   function automatic logic [BEAT_BITS-1:0] entry_start(input note_entry_t e);
      return e[START_LSB +: BEAT_BITS];
   endfunction

   function automatic logic [BEAT_BITS-1:0] entry_duration(input note_entry_t e);
      return e[DUR_LSB +: BEAT_BITS];
   endfunction

endpackage

// File: rtl/note_window_match.sv
// Classifies one song entry against the visible beat window: overlapping,
// already ended, or the end-of-song terminator.
module note_window_match
   import iscore_pkg::*;
(
   input  logic [NOTE_STATE_BITS-1:0] entry,
   input  logic [BEAT_BITS-1:0]       win_s,
   input  logic [BEAT_BITS:0]         win_e,
   output logic                       overlap,
   output logic                       ended,
   output logic                       terminator
);

   logic [BEAT_BITS:0] start_x;
   logic [BEAT_BITS:0] end_x;
   logic [BEAT_BITS:0] win_s_x;
   logic               unused_note;

   assign start_x     = {1'b0, entry_start(entry)};
   assign end_x       = start_x + {1'b0, entry_duration(entry)};
   assign win_s_x     = {1'b0, win_s};
   assign unused_note = ^entry[NOTE_LSB +: NOTE_BITS];

   assign overlap    = (start_x < win_e) && (end_x > win_s_x);
   assign ended      = (end_x <= win_s_x);
   assign terminator = (entry_duration(entry) == '0);

endmodule

// File: rtl/note_window.sv
// Scans song memory for entries overlapping the beat window into a shadow
// array, swapped to the front array at frame_sync. Option: NOTE_WINDOW_OVF_EN.
module note_window
   import iscore_pkg::*;
(
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic [BEAT_BITS-1:0]                         cur_beat,
   input  logic                                         req,
   output logic                                         req_ready,
   input  logic                                         frame_sync,
   output logic [ADDR_BITS-1:0]                         mem_addr,
   output logic                                         mem_rd,
   input  logic [NOTE_STATE_BITS-1:0]                   mem_data,
   output logic [NOTE_STATE_BITS*NOTES_STATE_SIZE-1:0] notes,
   output logic                                         valid
`ifdef NOTE_WINDOW_OVF_EN
   ,
   output logic                                         overflow
`endif
);

   localparam logic [BEAT_BITS:0]   SPAN      = (BEAT_BITS+1)'(WINDOW_SPAN);
   localparam logic [SLOT_BITS-1:0] SLOT_FULL = SLOT_BITS'(NOTES_STATE_SIZE);
   localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);

   nw_state_t state;
   nw_state_t next_state;

   logic [BEAT_BITS-1:0] win_s;
   logic [BEAT_BITS:0]   win_e;
   logic [ADDR_BITS-1:0] ptr;
   logic [ADDR_BITS-1:0] base_ptr;
   logic [SLOT_BITS-1:0] slot;
   logic                 live_seen;

   note_entry_t shadow [NOTES_STATE_SIZE];
   note_entry_t front  [NOTES_STATE_SIZE];

   logic overlap;
   logic ended;
   logic terminator;
   logic past;
   logic rewind;

   logic accept;
   logic do_write;
   logic do_step;
   logic do_base;
   logic do_swap;

   assign win_e  = {1'b0, win_s} + SPAN;
   assign past   = {1'b0, entry_start(mem_data)} >= win_e;
   assign rewind = cur_beat < win_s;

   note_window_match u_match (
      .entry      (mem_data),
      .win_s      (win_s),
      .win_e      (win_e),
      .overlap    (overlap),
      .ended      (ended),
      .terminator (terminator)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= NW_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      do_write   = 1'b0;
      do_step    = 1'b0;
      do_base    = 1'b0;
      do_swap    = 1'b0;
      req_ready  = 1'b0;
      mem_rd     = 1'b0;
      mem_addr   = '0;
      case (state)
         NW_IDLE: begin
            req_ready = 1'b1;
            if (req) begin
               accept     = 1'b1;
               next_state = NW_ISSUE;
            end
         end
         NW_ISSUE: begin
            mem_rd     = 1'b1;
            mem_addr   = ptr;
            next_state = NW_EVAL;
         end
         NW_EVAL: begin
            if (terminator || past) begin
               next_state = NW_DONE;
            end else begin
               do_step  = 1'b1;
               do_write = overlap && (slot < SLOT_FULL);
               // Only a leading run of finished entries may be skipped next scan.
               do_base  = ended && !live_seen;
               next_state = (ptr == '1) ? NW_DONE : NW_ISSUE;
            end
         end
         NW_DONE: begin
            if (frame_sync) begin
               do_swap    = 1'b1;
               next_state = NW_IDLE;
            end
         end
         default: next_state = NW_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_s     <= '0;
         ptr       <= '0;
         base_ptr  <= '0;
         slot      <= '0;
         live_seen <= 1'b0;
         valid     <= 1'b0;
         for (int unsigned i = 0; i < NOTES_STATE_SIZE; i++) begin
            shadow[i] <= EMPTY_ENTRY;
            front[i]  <= EMPTY_ENTRY;
         end
      end else begin
         if (accept) begin
            win_s     <= cur_beat;
            slot      <= '0;
            live_seen <= 1'b0;
            ptr       <= rewind ? '0 : base_ptr;
            if (rewind) begin
               base_ptr <= '0;
            end
            for (int unsigned i = 0; i < NOTES_STATE_SIZE; i++) begin
               shadow[i] <= EMPTY_ENTRY;
            end
         end
         if (do_write) begin
            shadow[slot[IDX_BITS-1:0]] <= mem_data;
            slot <= slot + SLOT_BITS'(1);
         end
         if (do_step) begin
            ptr <= ptr + ADDR_ONE;
            if (!ended) begin
               live_seen <= 1'b1;
            end
         end
         if (do_base) begin
            base_ptr <= ptr + ADDR_ONE;
         end
         if (do_swap) begin
            front <= shadow;
            valid <= 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NOTES_STATE_SIZE; g++) begin : g_flat
      assign notes[g*NOTE_STATE_BITS +: NOTE_STATE_BITS] = front[g];
   end

`ifdef NOTE_WINDOW_OVF_EN
   logic do_drop;

   assign do_drop = (state == NW_EVAL) && !(terminator || past) && overlap && (slot == SLOT_FULL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (accept) begin
         overflow <= 1'b0;
      end else if (do_drop) begin
         overflow <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_note_window.sv
// Directed self-checking bench for note_window with a 1-cycle-latency song
// memory model; overflow checks are built only with NOTE_WINDOW_OVF_EN.
module tb_note_window;
   import iscore_pkg::*;

   logic                                         clk = 1'b0;
   logic                                         rst;
   logic [BEAT_BITS-1:0]                         cur_beat;
   logic                                         req;
   logic                                         req_ready;
   logic                                         frame_sync;
   logic [ADDR_BITS-1:0]                         mem_addr;
   logic                                         mem_rd;
   logic [NOTE_STATE_BITS-1:0]                   mem_data = '0;
   logic [NOTE_STATE_BITS*NOTES_STATE_SIZE-1:0] notes;
   logic                                         valid;
`ifdef NOTE_WINDOW_OVF_EN
   logic                                         overflow;
`endif

   note_window dut (
      .clk        (clk),
      .rst        (rst),
      .cur_beat   (cur_beat),
      .req        (req),
      .req_ready  (req_ready),
      .frame_sync (frame_sync),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
      .mem_data   (mem_data),
      .notes      (notes),
      .valid      (valid)
`ifdef NOTE_WINDOW_OVF_EN
      ,
      .overflow   (overflow)
`endif
   );

   always #5 clk = ~clk;

   logic [NOTE_STATE_BITS-1:0] mem [0:4095];
   logic [ADDR_BITS-1:0]       rd_addr [0:1023];
   int unsigned                n_reads = 0;

   always @(posedge clk) begin
      if (mem_rd) begin
         mem_data               <= mem[mem_addr];
         rd_addr[n_reads % 1024] <= mem_addr;
         n_reads                <= n_reads + 1;
      end
   end

   int n_asserts = 0;
   int n_fail    = 0;
   logic [NOTE_STATE_BITS-1:0] exp_slots [NOTES_STATE_SIZE];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NOTE_STATE_BITS-1:0] ent(input int n, input int s, input int d);
      return {NOTE_BITS'(n), BEAT_BITS'(s), BEAT_BITS'(d)};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 4096; i++) mem[i] = '0;
   endtask

   task automatic clear_exp();
      for (int i = 0; i < NOTES_STATE_SIZE; i++) exp_slots[i] = '0;
   endtask

   task automatic check_slots(input string tag);
      for (int i = 0; i < NOTES_STATE_SIZE; i++)
         check($sformatf("%s_slot%0d", tag, i),
               64'(notes[i*NOTE_STATE_BITS +: NOTE_STATE_BITS]), 64'(exp_slots[i]));
   endtask

   task automatic start_req(input logic [BEAT_BITS-1:0] cb, output int unsigned snap);
      @(negedge clk);
      cur_beat = cb;
      req      = 1'b1;
      snap     = n_reads;
      @(negedge clk);
      req = 1'b0;
      check("accept_busy", req_ready, 0);
   endtask

   task automatic wait_done();
      int idle = 0;
      bit ok   = 1'b0;
      for (int c = 0; c < 20000; c++) begin
         @(negedge clk);
         if (mem_rd) idle = 0;
         else idle++;
         if (idle >= 3) begin
            ok = 1'b1;
            break;
         end
      end
      check("done_in_time", ok, 1);
   endtask

   task automatic swap();
      @(negedge clk);
      frame_sync = 1'b1;
      @(negedge clk);
      frame_sync = 1'b0;
      check("swap_valid", valid, 1);
      check("swap_ready", req_ready, 1);
   endtask

   task automatic run_scan(input string tag, input logic [BEAT_BITS-1:0] cb,
                           input int unsigned exp_reads, input int unsigned exp_first);
      int unsigned snap;
      start_req(cb, snap);
      wait_done();
      swap();
      check({tag, "_reads"}, 64'(n_reads - snap), 64'(exp_reads));
      check({tag, "_first"}, 64'(rd_addr[snap % 1024]), 64'(exp_first));
      check_slots(tag);
   endtask

   initial begin
      int unsigned snap;
      rst        = 1'b1;
      req        = 1'b0;
      frame_sync = 1'b0;
      cur_beat   = '0;
      clear_mem();
      clear_exp();
      #1;
      check("rst_valid", valid, 0);
      check("rst_ready", req_ready, 1);
      check("rst_mem_rd", mem_rd, 0);
      check("rst_mem_addr", mem_addr, 0);
      check_slots("rst");
`ifdef NOTE_WINDOW_OVF_EN
      check("rst_overflow", overflow, 0);
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // frame_sync with no scan pending must not publish anything
      @(negedge clk);
      frame_sync = 1'b1;
      @(negedge clk);
      frame_sync = 1'b0;
      check("idle_sync_valid", valid, 0);

      // Basic window at beat 0, with exact DONE timing and req/frame_sync collision
      mem[0] = ent(60, 0, 48);
      mem[1] = ent(62, 48, 96);
      mem[2] = ent(64, 400, 48);
      @(negedge clk);
      cur_beat = 16'd0;
      req      = 1'b1;
      snap     = n_reads;
      @(negedge clk);
      req = 1'b0;
      check("t1_busy", req_ready, 0);
      repeat (5) @(negedge clk);
      frame_sync = 1'b1;
      @(negedge clk);
      check("t1_early_sync_valid", valid, 0);
      check("t1_done_no_rd", mem_rd, 0);
      check("t1_done_busy", req_ready, 0);
      req = 1'b1;
      @(negedge clk);
      frame_sync = 1'b0;
      req        = 1'b0;
      check("t1_valid", valid, 1);
      check("t1_req_ignored", req_ready, 1);
      check("t1_reads", 64'(n_reads - snap), 3);
      check("t1_first", 64'(rd_addr[snap % 1024]), 0);
      exp_slots[0] = ent(60, 0, 48);
      exp_slots[1] = ent(62, 48, 96);
      check_slots("t1");

      // Window at beat 100: first entry ended, base pointer advances to 1
      clear_exp();
      exp_slots[0] = ent(62, 48, 96);
      run_scan("t2", 16'd100, 3, 0);
      run_scan("t2b", 16'd100, 2, 1);

      // Long note keeps base pointer at 0 despite a later ended entry
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      clear_mem();
      mem[0] = ent(50, 0, 500);
      mem[1] = ent(60, 10, 10);
      clear_exp();
      exp_slots[0] = ent(50, 0, 500);
      run_scan("t3", 16'd200, 3, 0);
      run_scan("t3b", 16'd200, 3, 0);

      // 33 overlapping entries: the last one has no slot
      clear_mem();
      clear_exp();
      for (int i = 0; i < 33; i++) mem[i] = ent(i + 1, 200 + i, 10);
      for (int i = 0; i < NOTES_STATE_SIZE; i++) exp_slots[i] = ent(i + 1, 200 + i, 10);
      run_scan("t4", 16'd200, 34, 0);
`ifdef NOTE_WINDOW_OVF_EN
      check("t4_overflow", overflow, 1);
`endif

      // Beat 300 ends every entry, then rewinding to 0 must restart at address 0
      clear_exp();
      run_scan("t5a", 16'd300, 34, 0);
`ifdef NOTE_WINDOW_OVF_EN
      check("t5_overflow_clear", overflow, 0);
`endif
      clear_mem();
      mem[0] = ent(60, 0, 48);
      mem[1] = ent(62, 48, 96);
      mem[2] = ent(64, 400, 48);
      exp_slots[0] = ent(60, 0, 48);
      exp_slots[1] = ent(62, 48, 96);
      run_scan("t5b", 16'd0, 3, 0);

      // Reset while evaluating an entry
      start_req(16'd0, snap);
      @(negedge clk);
      rst = 1'b1;
      #1;
      clear_exp();
      check("t6_valid", valid, 0);
      check("t6_ready", req_ready, 1);
      check("t6_mem_rd", mem_rd, 0);
      check("t6_mem_addr", mem_addr, 0);
      check_slots("t6");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      frame_sync = 1'b1;
      @(negedge clk);
      frame_sync = 1'b0;
      repeat (2) @(negedge clk);
      check("t6_sync_no_req_valid", valid, 0);
      check("t6_idle_ready", req_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/note_window.md
# note_window

Upstream feeder for the pixel renderer. Scans the song's note memory, gathers every (note, start, duration) entry that overlaps the visible beat window, and builds it into a shadow array. At a frame boundary it swaps that array into the `notes` bus and asserts `valid`, so a frame never shows a half-updated note set. It consumes `cur_beat` from the playback sequencer and drives `notes`/`valid` of `display`.

## Interface
- DISPLAYED_BEATS, 4, beats visible on screen
- SIMULTANEOUS_NOTES, 4, notes displayable at once per beat
- BEAT_DURATION, 48, beat length in beat48 units
- BEAT_BITS, 16, width of a beat48 position or duration
- NOTE_BITS, 7, width of a note code
- ADDR_BITS, 12, song memory address width
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cur_beat  in  BEAT_BITS  playback position (beat48 units), window start
- req  in  1  update request; accepted when `req_ready`=1
- req_ready  out  1  high in IDLE only
- frame_sync  in  1  one-cycle pulse at end of visible frame
- mem_addr  out  ADDR_BITS  song memory read address
- mem_rd  out  1  read strobe; data returns exactly 1 cycle later
- mem_data  in  NOTE_STATE_BITS  entry {note, start, duration}, MSB→LSB
- notes  out  NOTE_STATE_BITS × NOTES_STATE_SIZE  front array, NOTES_STATE_SIZE = 2·DISPLAYED_BEATS·SIMULTANEOUS_NOTES
- valid  out  1  front array holds a completed scan

## Operation
- Song memory holds entries sorted by ascending start. An entry with duration 0 is the terminator.
- Window: win_s = cur_beat (latched on accept); win_e = win_s + DISPLAYED_BEATS·BEAT_DURATION.
- Entry overlaps when start < win_e and start+duration > win_s.
- All sums are computed at BEAT_BITS+1 bits; there is no wrap.
- base_ptr: index of the first entry not yet known to have ended. It resets to 0, and is also reset to 0 when a latched win_s is less than the previous win_s (rewind).
- FSM:
  - IDLE: on req, latch win_s, clear the shadow array to all-zero, set slot=0 and ptr=base_ptr, then go to ISSUE.
  - ISSUE: mem_rd=1, mem_addr=ptr, go to EVAL.
  - EVAL, evaluated in this priority order:
    - terminator or start ≥ win_e → DONE.
    - overlap and slot < NOTES_STATE_SIZE → write shadow[slot], slot++.
    - entry ended (start+duration ≤ win_s) and no earlier entry in this scan was still live → base_ptr = ptr+1.
    - ptr++. If ptr wraps to 0 (address space exhausted) → DONE; otherwise → ISSUE.
  - DONE: wait for frame_sync, copy shadow to front, go to IDLE.
- An overlapping entry found when slot = NOTES_STATE_SIZE is dropped and the scan continues.
- Unused slots stay all-zero (duration 0 = empty slot).

## Timing
- Reset values: notes all-zero, valid=0, req_ready=1, mem_rd=0, mem_addr=0. Internally: base_ptr=0, FSM=IDLE.
- Reset mid-scan aborts the scan. The front array is cleared.
- req is sampled only when req_ready=1. req while busy is ignored and not queued.
- Scan cost: 2 cycles per entry read. DONE is reached 2·N cycles after the accept edge (N = entries read).
- frame_sync during IDLE/ISSUE/EVAL has no effect.
- frame_sync in DONE: front array updates on that edge. valid goes 1 on the same edge and stays 1 until reset.
- req and frame_sync coinciding in DONE: the swap happens; req is ignored (req_ready=0 that cycle). req_ready=1 from the next cycle.

## Configuration
- NOTE_WINDOW_OVF_EN defined: adds output `overflow` (1 bit, reset 0).
  - Set sticky when an overlapping entry is dropped for lack of a slot.
  - Cleared on accept of the next req.
- NOTE_WINDOW_OVF_EN undefined: the port and its logic are absent. Drops are silent.

## Structure
- Shared package `iscore_pkg`:
  - NOTE_STATE_BITS and NOTES_STATE_SIZE derivations
  - note-entry field offsets (note/start/duration)
  - EMPTY_ENTRY constant (all-zero)
  - FSM state enum
  - screen constants shared with `display`
- One sub-module, `note_window_match`: combinational; inputs entry, win_s and win_e; outputs overlap, ended and terminator flags. It is instantiated once in EVAL.

## Test plan
- Entries {60,0,48},{62,48,96},{64,400,48},term; cur_beat=0; req, then frame_sync → after swap, notes[0..1] hold the first two entries, rest zero, valid=1; the third entry is excluded (400 ≥ 192).
- Same memory, cur_beat=100 → only {62,48,96} is present; base_ptr=1 afterwards.
- Long note {50,0,500} followed by {60,10,10}, cur_beat=200 → {50,0,500} is kept; base_ptr stays 0.
- 33 overlapping entries, NOTES_STATE_SIZE=32 → slots 0..31 filled, entry 33 dropped; overflow=1 when NOTE_WINDOW_OVF_EN is set.
- req at cur_beat=300, then at cur_beat=0 → rewind; base_ptr=0; results are correct.
- rst asserted mid-EVAL → notes zero, valid=0, req_ready=1 immediately. frame_sync without a prior req leaves valid=0.
